xtop_calc: RTL and testbench
============================

XTOP_CALC -- requirements
Module: xtop_calc

Interface
REQ-001 SHALL have parameter REFRESH_W, default 2, log2 of clock cycles each display digit is shown.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port Btn3, input, 1, asynchronous "load operands" button, active-high.
REQ-005 SHALL have port Btn2, input, 1, asynchronous "execute operation" button, active-high.
REQ-006 SHALL have port Sw, input, 8, operand/opcode switches.
REQ-007 SHALL have port Led, output, 8, registered copy of captured operands {a_sm, b_sm}.
REQ-008 SHALL have port Disp, output, 8, active-low segments {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port Disp_sel, output, 4, active-low one-hot digit enable; bit0 = rightmost digit.
REQ-010 SHALL have port trap, output, 1, registered error flag.

Function
REQ-011 Btn3 and Btn2 SHALL each pass a 2-flop synchroniser plus rising-edge detector; synchroniser flops reset to 0, so a button already high at reset release yields one edge.
REQ-012 On a Btn3 edge: a <= Sw[7:4], b <= Sw[3:0], both 4-bit sign-magnitude (bit3 = sign, bits2:0 = magnitude, range -7..+7; -0 treated as 0); Led <= Sw.
REQ-013 On a Btn2 edge: op <= Sw[1:0]; 00 = a+b, 01 = a*b, 10 = a/b truncated toward zero, 11 = a-b.
REQ-014 Both edges in the same cycle SHALL both take effect.
REQ-015 result (signed, range -49..+49) SHALL register ALU(a,b,op) every cycle; latency 1 cycle after a/b/op update, so display reflects a button edge 4 cycles after the raw input rises (2 sync + 1 capture + 1 result).
REQ-016 op=10 with b magnitude 0: result <= 0 and trap <= 1; trap SHALL be 0 in every other case, updated the same cycle as result.
REQ-017 Display digits: digit0 = units of |result|; digit1 = tens of |result|, blank if zero; digit2 = '-' if result<0, else blank; digit3 = blank.
REQ-018 Segment codes (Disp): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 hex, '-'=BF, blank=FF; dp always off.
REQ-019 Free-running refresh counter of REFRESH_W+2 bits; upper 2 bits select digit 0,1,2,3, wrapping 3->0; Disp_sel and Disp SHALL be registered and change together.
REQ-020 Sw changes without a button edge SHALL have no effect.

Reset
REQ-021 While rst=0: a=b=0, op=00, result=0, trap=0, Led=00, Disp=FF, Disp_sel=1111, refresh counter=0, synchroniser and edge flops=0.
REQ-022 First cycle after release SHALL drive digit0 (Disp_sel=1110, Disp=C0); reset asserted mid-operation SHALL immediately force REQ-021 values.

Structure
REQ-023 Shared package xcalc_pkg SHALL hold opcode constants, the 12 segment codes, and REFRESH_W default.
REQ-024 One sub-module seg7_mux SHALL contain the refresh counter, binary-to-digit split and segment/select registers; ALU, button logic and operand registers stay in xtop_calc.

Verification
REQ-025 Reset with Btn3=1, Sw=F3 -> after release, a=-7, b=3, op=add, result=-4; scan shows digit2 BF, digit1 FF, digit0 99.
REQ-026 Then Btn3=0, Btn2=1, Sw=01 -> within 4 cycles result=-21; digits BF, A4, F9; trap=0.
REQ-027 Btn2 with Sw=02 on a=-7,b=3 -> result=-2 (BF, FF, A4); Sw=03 -> result=-10 (BF, F9, C0).
REQ-028 Btn3 Sw=70 (a=7,b=0), Btn2 Sw=02 -> trap=1, result=0 (digits FF, FF, C0); then Btn2 Sw=00 -> trap=0, result=7.
REQ-029 Btn3 Sw=77, Btn2 Sw=01 -> result=49 (FF, 99, 90); Disp_sel sequence 1110,1101,1011,0111 each held 2**REFRESH_W cycles, then wraps.
REQ-030 Assert rst mid-scan -> all outputs go to REQ-021 values without waiting for clk.

Source files
------------

// File: rtl/xcalc_pkg.sv
// Shared constants for the sign-magnitude calculator: opcodes, seven-segment
// codes and the default display refresh width.
package xcalc_pkg;

    localparam int REFRESH_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is off in every code.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_mux.sv
// Time-multiplexed 4-digit seven-segment driver: splits a signed result into
// sign/tens/units and scans the digits with registered segment/select outputs.
module seg7_mux
    import xcalc_pkg::*;
#(
    parameter int REFRESH_W = REFRESH_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [6:0] i_result,
    output logic [7:0]        o_disp,
    output logic [3:0]        o_sel
);

    logic [REFRESH_W+1:0] r_cnt;
    logic [1:0]           w_digit_idx;
    logic [5:0]           w_abs;
    logic [3:0]           w_tens;
    logic [3:0]           w_units;
    logic [7:0]           w_seg_next;
    logic [3:0]           w_sel_next;

    assign w_digit_idx = r_cnt[REFRESH_W+1 -: 2];

    // Magnitude and decimal split of the result (|result| <= 49).
    always_comb begin
        if (i_result[6]) begin
            w_abs = 6'(-i_result);
        end else begin
            w_abs = i_result[5:0];
        end
        w_tens  = 4'(w_abs / 6'd10);
        w_units = 4'(w_abs % 6'd10);
    end

    // Segment pattern and digit enable for the digit currently being scanned.
    always_comb begin
        w_seg_next = SEG_BLANK;
        w_sel_next = 4'b1111;
        case (w_digit_idx)
            2'd0: begin
                w_sel_next = 4'b1110;
                w_seg_next = seg_of_digit(w_units);
            end
            2'd1: begin
                w_sel_next = 4'b1101;
                w_seg_next = (w_tens == 4'd0) ? SEG_BLANK : seg_of_digit(w_tens);
            end
            2'd2: begin
                w_sel_next = 4'b1011;
                w_seg_next = i_result[6] ? SEG_MINUS : SEG_BLANK;
            end
            2'd3: begin
                w_sel_next = 4'b0111;
                w_seg_next = SEG_BLANK;
            end
            default: begin
                w_sel_next = 4'b1111;
                w_seg_next = SEG_BLANK;
            end
        endcase
    end

    // Refresh counter and registered display outputs, updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            o_disp <= SEG_BLANK;
            o_sel  <= 4'b1111;
        end else begin
            r_cnt  <= r_cnt + (REFRESH_W+2)'(1);
            o_disp <= w_seg_next;
            o_sel  <= w_sel_next;
        end
    end

endmodule

// File: rtl/xtop_calc.sv
// Button-driven sign-magnitude calculator: synchronised buttons capture
// operands and opcode, a registered ALU feeds the multiplexed display.
module xtop_calc
    import xcalc_pkg::*;
#(
    parameter int REFRESH_W = REFRESH_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Btn3,
    input  logic       Btn2,
    input  logic [7:0] Sw,
    output logic [7:0] Led,
    output logic [7:0] Disp,
    output logic [3:0] Disp_sel,
    output logic       trap
);

    logic [1:0]        r_b3_sync;
    logic [1:0]        r_b2_sync;
    logic              r_b3_dly;
    logic              r_b2_dly;
    logic [3:0]        r_a;
    logic [3:0]        r_b;
    op_e               r_op;
    logic [7:0]        r_led;
    logic signed [6:0] r_result;
    logic              r_trap;

    logic              w_b3_edge;
    logic              w_b2_edge;
    logic signed [6:0] w_a_val;
    logic signed [6:0] w_b_val;
    logic [5:0]        w_prod_mag;
    logic [2:0]        w_quot_mag;
    logic              w_neg;
    logic signed [6:0] w_alu;
    logic              w_div0;

    assign w_b3_edge = r_b3_sync[1] & ~r_b3_dly;
    assign w_b2_edge = r_b2_sync[1] & ~r_b2_dly;

    // Button synchronisers, edge detectors and operand/opcode capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b3_sync <= 2'b00;
            r_b2_sync <= 2'b00;
            r_b3_dly  <= 1'b0;
            r_b2_dly  <= 1'b0;
            r_a       <= 4'h0;
            r_b       <= 4'h0;
            r_op      <= OP_ADD;
            r_led     <= 8'h00;
        end else begin
            r_b3_sync <= {r_b3_sync[0], Btn3};
            r_b2_sync <= {r_b2_sync[0], Btn2};
            r_b3_dly  <= r_b3_sync[1];
            r_b2_dly  <= r_b2_sync[1];
            if (w_b3_edge) begin
                r_a   <= Sw[7:4];
                r_b   <= Sw[3:0];
                r_led <= Sw;
            end
            if (w_b2_edge) begin
                r_op <= op_e'(Sw[1:0]);
            end
        end
    end

    // Sign-magnitude ALU; mul/div work on magnitudes so -0 and truncation are exact.
    always_comb begin
        w_a_val    = {4'b0000, r_a[2:0]};
        w_b_val    = {4'b0000, r_b[2:0]};
        w_prod_mag = {3'b000, r_a[2:0]} * {3'b000, r_b[2:0]};
        w_quot_mag = 3'd0;
        w_neg      = r_a[3] ^ r_b[3];
        w_alu      = 7'sd0;
        w_div0     = 1'b0;
        if (r_a[3]) begin
            w_a_val = -w_a_val;
        end else begin
            w_a_val = w_a_val;
        end
        if (r_b[3]) begin
            w_b_val = -w_b_val;
        end else begin
            w_b_val = w_b_val;
        end
        if (r_b[2:0] != 3'd0) begin
            w_quot_mag = r_a[2:0] / r_b[2:0];
        end else begin
            w_quot_mag = 3'd0;
        end
        case (r_op)
            OP_ADD: w_alu = w_a_val + w_b_val;
            OP_SUB: w_alu = w_a_val - w_b_val;
            OP_MUL: w_alu = w_neg ? -$signed({1'b0, w_prod_mag})
                                  :  $signed({1'b0, w_prod_mag});
            OP_DIV: begin
                if (r_b[2:0] == 3'd0) begin
                    w_div0 = 1'b1;
                    w_alu  = 7'sd0;
                end else begin
                    w_div0 = 1'b0;
                    w_alu  = w_neg ? -$signed({4'b0000, w_quot_mag})
                                   :  $signed({4'b0000, w_quot_mag});
                end
            end
            default: w_alu = 7'sd0;
        endcase
    end

    // Result and trap register every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= 7'sd0;
            r_trap   <= 1'b0;
        end else begin
            r_result <= w_alu;
            r_trap   <= w_div0;
        end
    end

    assign Led  = r_led;
    assign trap = r_trap;

    seg7_mux #(
        .REFRESH_W (REFRESH_W)
    ) u_seg7_mux (
        .clk      (clk),
        .rst_n    (rst),
        .i_result (r_result),
        .o_disp   (Disp),
        .o_sel    (Disp_sel)
    );

endmodule

// File: tb/tb_xtop_calc.sv
// Directed testbench for xtop_calc with hand-computed expected values.
module tb_xtop_calc;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       Btn3 = 1'b0;
    logic       Btn2 = 1'b0;
    logic [7:0] Sw   = 8'h00;
    logic [7:0] Led;
    logic [7:0] Disp;
    logic [3:0] Disp_sel;
    logic       trap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xtop_calc #(.REFRESH_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .Btn3     (Btn3),
        .Btn2     (Btn2),
        .Sw       (Sw),
        .Led      (Led),
        .Disp     (Disp),
        .Disp_sel (Disp_sel),
        .trap     (trap)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int res_now();
        return int'(dut.r_result);
    endfunction

    // Observe one full scan (16 cycles at REFRESH_W=2) and record each digit.
    task automatic scan_check(input string tag, input int e2, input int e1, input int e0);
        int d0 = -1, d1 = -1, d2 = -1, d3 = -1;
        repeat (16) begin
            @(negedge clk);
            case (Disp_sel)
                4'b1110: d0 = int'(Disp);
                4'b1101: d1 = int'(Disp);
                4'b1011: d2 = int'(Disp);
                4'b0111: d3 = int'(Disp);
                default: ;
            endcase
        end
        check({tag, "_dig3"}, d3, 32'hFF);
        check({tag, "_dig2"}, d2, e2);
        check({tag, "_dig1"}, d1, e1);
        check({tag, "_dig0"}, d0, e0);
    endtask

    task automatic press(input logic b3, input logic b2, input logic [7:0] sw);
        @(negedge clk);
        Sw   = sw;
        Btn3 = b3;
        Btn2 = b2;
        repeat (6) @(negedge clk);
        Btn3 = 1'b0;
        Btn2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [3:0] pat [4];
    int         bad;
    int         found;

    initial begin
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

        // Reset held with Btn3 already pressed
        rst  = 1'b0;
        Btn3 = 1'b1;
        Sw   = 8'hF3;
        repeat (3) @(negedge clk);
        check("rst_disp", int'(Disp), 32'hFF);
        check("rst_sel", int'(Disp_sel), 32'hF);
        check("rst_led", int'(Led), 0);
        check("rst_trap", int'(trap), 0);
        check("rst_result", res_now(), 0);

        rst = 1'b1;
        @(posedge clk); #1;
        check("first_sel", int'(Disp_sel), 32'hE);
        check("first_disp", int'(Disp), 32'hC0);

        repeat (8) @(negedge clk);
        check("add_led", int'(Led), 32'hF3);
        check("add_result", res_now(), -4);
        check("add_trap", int'(trap), 0);
        scan_check("add", 32'hBF, 32'hFF, 32'h99);

        // Latency: result moves exactly on the 4th edge after the raw press
        @(negedge clk);
        Btn3 = 1'b0;
        Btn2 = 1'b1;
        Sw   = 8'h01;
        repeat (3) @(posedge clk); #1;
        check("mul_lat3", res_now(), -4);
        @(posedge clk); #1;
        check("mul_lat4", res_now(), -21);
        repeat (4) @(negedge clk);
        Btn2 = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_led_hold", int'(Led), 32'hF3);
        check("mul_trap", int'(trap), 0);
        scan_check("mul", 32'hBF, 32'hA4, 32'hF9);

        press(1'b0, 1'b1, 8'h02);
        check("div_result", res_now(), -2);
        scan_check("div", 32'hBF, 32'hFF, 32'hA4);

        press(1'b0, 1'b1, 8'h03);
        check("sub_result", res_now(), -10);
        scan_check("sub", 32'hBF, 32'hF9, 32'hC0);

        press(1'b1, 1'b0, 8'h70);
        press(1'b0, 1'b1, 8'h02);
        check("div0_trap", int'(trap), 1);
        check("div0_result", res_now(), 0);
        check("div0_led", int'(Led), 32'h70);
        scan_check("div0", 32'hFF, 32'hFF, 32'hC0);

        press(1'b0, 1'b1, 8'h00);
        check("clr_trap", int'(trap), 0);
        check("clr_result", res_now(), 7);

        // Both buttons in the same cycle
        press(1'b1, 1'b1, 8'hA2);
        check("both_led", int'(Led), 32'hA2);
        check("both_result", res_now(), -1);
        scan_check("both", 32'hBF, 32'hFF, 32'hF9);

        press(1'b1, 1'b1, 8'h8B);
        check("negzero_result", res_now(), 3);
        scan_check("negzero", 32'hFF, 32'hFF, 32'hB0);

        press(1'b1, 1'b0, 8'h77);
        press(1'b0, 1'b1, 8'h01);
        check("max_result", res_now(), 49);
        scan_check("max", 32'hFF, 32'h99, 32'h90);

        // Select sequence: align to the first cycle of digit0, then check 4 scans
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (Disp_sel != 4'b1110) found = 1;
        end
        for (int i = 0; i < 20 && found == 1; i++) begin
            @(negedge clk);
            if (Disp_sel == 4'b1110) found = 2;
        end
        check("sel_align", found, 2);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (Disp_sel !== pat[(k / 4) % 4]) bad++;
            @(negedge clk);
        end
        check("sel_sequence", bad, 0);

        // Asynchronous reset mid-scan, away from any clock edge
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("async_disp", int'(Disp), 32'hFF);
        check("async_sel", int'(Disp_sel), 32'hF);
        check("async_led", int'(Led), 0);
        check("async_trap", int'(trap), 0);
        check("async_result", res_now(), 0);
        #20;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
